vote_vector_sequencer: RTL and testbench

Exhaustive stimulus sequencer and response checker for the 4-input "at least three of four" vote combinational block. On a start pulse it drives all 16 input combinations onto `a,b,c,d`. After a programmable settle delay it samples the block's sum-of-minterms and product-of-maxterms outputs for each combination. It compares both against the golden value, counts mismatches and records the first failing vector. It sits on the board/bench side of the vote block and provides a self-test with pass/fail status.

---
 rtl/vote_vector_sequencer.sv | 106 ++++++++++
 tb/tb_vote_vector_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vote_vector_sequencer.sv
// Self-test sequencer for the "at least three of four" vote block: sweeps all 16
// input vectors, samples both response forms after SETTLE cycles, and reports results.
module vote_vector_sequencer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   input  logic       somin_in,
   input  logic       pomax_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic       fail_valid,
   output logic [3:0] fail_index,
   output logic [1:0] dbg_state
);

   // Request handshake: start is a one-cycle request, accepted only in IDLE
   // (busy low); any start seen while a sweep is running is dropped, never queued.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LAST = 4'(SETTLE - 1);

   state_t     state_q, state_d;
   logic [3:0] idx_q;
   logic [3:0] wait_q;
   logic [2:0] ones;
   logic       golden;
   logic       mismatch;

   always_comb begin
      ones     = 3'(idx_q[3]) + 3'(idx_q[2]) + 3'(idx_q[1]) + 3'(idx_q[0]);
      golden   = (ones >= 3'd3);
      mismatch = (somin_in != golden) || (pomax_in != golden);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = DRIVE;
         DRIVE:   if (wait_q == WAIT_LAST) state_d = SAMPLE;
         SAMPLE:  state_d = (idx_q == 4'd15) ? FINISH : DRIVE;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= 4'd0;
         wait_q     <= 4'd0;
         err_count  <= 5'd0;
         fail_valid <= 1'b0;
         fail_index <= 4'd0;
         pass       <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  idx_q      <= 4'd0;
                  wait_q     <= 4'd0;
                  err_count  <= 5'd0;
                  fail_valid <= 1'b0;
                  fail_index <= 4'd0;
                  pass       <= 1'b0;
               end
            end
            DRIVE: begin
               wait_q <= (wait_q == WAIT_LAST) ? 4'd0 : wait_q + 4'd1;
            end
            SAMPLE: begin
               if (mismatch) begin
                  err_count <= err_count + 5'd1;
                  if (!fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_index <= idx_q;
                  end
               end
               // pass must already include this last sample when done is shown
               if (idx_q == 4'd15) pass <= (err_count == 5'd0) && !mismatch;
               else                idx_q <= idx_q + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign {a, b, c, d} = idx_q;
   assign busy         = (state_q == DRIVE) || (state_q == SAMPLE);
   assign done         = (state_q == FINISH);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_vote_vector_sequencer.sv
// Bench for vote_vector_sequencer: table-driven fault models, random fault masks
// against a vector-level reference model, and multi-cycle corner sequences.
module tb_vote_vector_sequencer;

   logic clk = 1'b0;
   logic rst, start, start_slow;
   always #5 clk = ~clk;

   // SETTLE=1 instance with a table-programmable combinational response model
   logic [3:0]  v1;
   logic        somin1, pomax1, busy1, done1, pass1, fv1;
   logic [4:0]  err1;
   logic [3:0]  fi1;
   logic [1:0]  st1;
   logic [15:0] somin_bad, pomax_bad;

   // SETTLE=3 and SETTLE=2 instances driving a DUT with three register stages
   logic [3:0] v2, v3;
   logic       busy2, done2, pass2, fv2, busy3, done3, pass3, fv3;
   logic [4:0] err2, err3;
   logic [3:0] fi2, fi3;
   logic [1:0] st2, st3;
   logic [2:0] dly2, dly3;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic golden(input logic [3:0] k);
      return $countones(k) >= 3;
   endfunction

   always_comb begin
      somin1 = golden(v1) ^ somin_bad[v1];
      pomax1 = golden(v1) ^ pomax_bad[v1];
   end

   always @(posedge clk) begin
      dly2 <= {dly2[1:0], golden(v2)};
      dly3 <= {dly3[1:0], golden(v3)};
   end

   vote_vector_sequencer #(.SETTLE(1)) u1 (
      .clk(clk), .rst(rst), .start(start),
      .a(v1[3]), .b(v1[2]), .c(v1[1]), .d(v1[0]),
      .somin_in(somin1), .pomax_in(pomax1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
      .fail_valid(fv1), .fail_index(fi1), .dbg_state(st1)
   );

   vote_vector_sequencer #(.SETTLE(2)) u2 (
      .clk(clk), .rst(rst), .start(start_slow),
      .a(v2[3]), .b(v2[2]), .c(v2[1]), .d(v2[0]),
      .somin_in(dly2[2]), .pomax_in(dly2[2]),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
      .fail_valid(fv2), .fail_index(fi2), .dbg_state(st2)
   );

   vote_vector_sequencer #(.SETTLE(3)) u3 (
      .clk(clk), .rst(rst), .start(start_slow),
      .a(v3[3]), .b(v3[2]), .c(v3[1]), .d(v3[0]),
      .somin_in(dly3[2]), .pomax_in(dly3[2]),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
      .fail_valid(fv3), .fail_index(fi3), .dbg_state(st3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: a vector mismatches when either response differs from golden.
   task automatic model(input logic [15:0] sb, input logic [15:0] pb, output int e,
                        output logic fv, output int fi, output logic p);
      logic rs, rp;
      e = 0; fv = 1'b0; fi = 0;
      for (int k = 0; k < 16; k++) begin
         rs = golden(4'(k)) ^ sb[k];
         rp = golden(4'(k)) ^ pb[k];
         if (rs != golden(4'(k)) || rp != golden(4'(k))) begin
            e++;
            if (!fv) begin fv = 1'b1; fi = k; end
         end
      end
      p = (e == 0);
   endtask

   // One SETTLE=1 sweep; returns the result outputs seen in the done cycle.
   task automatic sweep1(input logic [15:0] sb, input logic [15:0] pb, input bit poke,
                         output int r_err, output logic r_fv, output int r_fi,
                         output logic r_pass);
      int seq_bad = 0;
      int partial;
      int r_done  = -1;
      somin_bad = sb;
      pomax_bad = pb;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("cleared_pass", 32'(pass1), 32'd0);
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         start = poke && (c == 10);
         if (done1) begin r_done = c; break; end
         if (busy1 !== 1'b1 || v1 !== 4'((c - 1) / 2)) seq_bad++;
         partial = 0;
         for (int k = 0; k < 16; k++)
            if ((sb[k] || pb[k]) && (2 * k + 2 < c)) partial++;
         if (err1 !== 5'(partial)) seq_bad++;
      end
      start = 1'b0;
      check("sweep_seq_errors", 32'(seq_bad), 32'd0);
      check("done_cycle", 32'(r_done), 32'd33);
      check("busy_at_done", 32'(busy1), 32'd0);
      r_err  = int'(err1);
      r_fv   = fv1;
      r_fi   = int'(fi1);
      r_pass = pass1;
      @(negedge clk);
      check("done_one_pulse", 32'(done1), 32'd0);
   endtask

   typedef struct {
      string       name;
      logic [15:0] sb;
      logic [15:0] pb;
      bit          poke;
      int          err;
      bit          fv;
      int          fi;
      bit          pass;
   } vec_t;

   vec_t tbl[7];

   task automatic set_vec(input int i, input string n, input logic [15:0] sb,
                          input logic [15:0] pb, input bit poke, input int e,
                          input bit fv, input int fi, input bit p);
      tbl[i].name = n; tbl[i].sb = sb; tbl[i].pb = pb; tbl[i].poke = poke;
      tbl[i].err = e; tbl[i].fv = fv; tbl[i].fi = fi; tbl[i].pass = p;
   endtask

   initial begin
      int          e, fi, r_err, r_fi, d2c, d3c;
      logic        fv, p, r_fv, r_pass, p2, p3, seen_done;
      logic [15:0] sb, pb;

      set_vec(0, "good",          16'h0000, 16'h0000, 0,  0, 0,  0, 1);
      set_vec(1, "pomax_stuck1",  16'h0000, 16'h177F, 0, 11, 1,  0, 0);
      set_vec(2, "v13_both",      16'h2000, 16'h2000, 0,  1, 1, 13, 0);
      set_vec(3, "all_wrong",     16'hFFFF, 16'hFFFF, 0, 16, 1,  0, 0);
      set_vec(4, "good_poked",    16'h0000, 16'h0000, 1,  0, 0,  0, 1);
      set_vec(5, "last_only",     16'h0000, 16'h8000, 0,  1, 1, 15, 0);
      set_vec(6, "somin_stuck0",  16'hE880, 16'h0000, 1,  5, 1,  7, 0);

      rst = 1'b1; start = 1'b0; start_slow = 1'b0;
      somin_bad = 16'h0; pomax_bad = 16'h0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            32'({v1, busy1, done1, pass1, err1, fv1, fi1}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         sweep1(tbl[i].sb, tbl[i].pb, tbl[i].poke, r_err, r_fv, r_fi, r_pass);
         check({tbl[i].name, "_err"},  32'(r_err),  32'(tbl[i].err));
         check({tbl[i].name, "_fv"},   32'(r_fv),   32'(tbl[i].fv));
         check({tbl[i].name, "_fi"},   32'(r_fi),   32'(tbl[i].fi));
         check({tbl[i].name, "_pass"}, 32'(r_pass), 32'(tbl[i].pass));
         repeat (2) @(negedge clk);
         check({tbl[i].name, "_pass_hold"}, 32'(pass1), 32'(tbl[i].pass));
         check({tbl[i].name, "_idle_vec"},  32'(v1), 32'd15);
      end

      for (int i = 0; i < 8; i++) begin
         sb = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
         pb = ($urandom_range(0, 1) == 0) ? (16'h1 << $urandom_range(0, 15)) : 16'h0;
         model(sb, pb, e, fv, fi, p);
         sweep1(sb, pb, 1'($urandom_range(0, 1)), r_err, r_fv, r_fi, r_pass);
         check("rand_err",  32'(r_err),  32'(e));
         check("rand_fv",   32'(r_fv),   32'(fv));
         check("rand_fi",   32'(r_fi),   32'(fi));
         check("rand_pass", 32'(r_pass), 32'(p));
         @(negedge clk);
      end

      // Reset in the middle of a failing sweep, then a clean sweep afterwards
      somin_bad = 16'h0000; pomax_bad = 16'h177F;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      check("rst_mid_outputs",
            32'({v1, busy1, done1, pass1, err1, fv1, fi1}), 32'd0);
      seen_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done1) seen_done = 1'b1;
      end
      check("rst_mid_no_done", 32'(seen_done), 32'd0);
      sweep1(16'h0, 16'h0, 0, r_err, r_fv, r_fi, r_pass);
      check("after_rst_pass", 32'(r_pass), 32'd1);
      check("after_rst_err",  32'(r_err),  32'd0);

      // Delayed DUT: SETTLE=3 must pass, SETTLE=2 must fail
      d2c = -1; d3c = -1; p2 = 1'bx; p3 = 1'bx;
      @(negedge clk) start_slow = 1'b1;
      @(negedge clk) start_slow = 1'b0;
      for (int c = 1; c <= 120; c++) begin
         if (c > 1) @(negedge clk);
         if (done2 && d2c < 0) begin d2c = c; p2 = pass2; end
         if (done3 && d3c < 0) begin d3c = c; p3 = pass3; end
         if (d3c >= 0 && d2c >= 0) break;
      end
      check("settle2_done_cycle", 32'(d2c), 32'd49);
      check("settle3_done_cycle", 32'(d3c), 32'd65);
      check("settle2_pass", 32'(p2), 32'd0);
      check("settle3_pass", 32'(p3), 32'd1);
      check("settle3_err",  32'(err3), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
